// File: rtl/id_stage_pipe.sv
// Registered RV32I(+M) decode stage with a 2-entry head/skid buffer.
// Also inserts load-use bubbles and supports a synchronous flush.
module id_stage_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1_addr,
  output logic [4:0]      out_rs2_addr,
  output logic [4:0]      out_rd_addr,
  output logic [2:0]      out_imm_type,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_alu_op,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic [15:0]     bubble_cnt
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_SLT    = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd9;
  localparam logic [3:0] ALU_MULDIV = 4'd10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [2:0]      imm_type;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic            uses_rs1;
    logic            uses_rs2;
  } entry_t;

  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  entry_t     dec;
  logic       dec_bad;
  logic       dec_range_bad;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  // Illegal decodes keep their register fields and imm type but report ADD with no side effects.
  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.rs1_addr  = in_inst[19:15];
    dec.rs2_addr  = in_inst[24:20];
    dec.rd_addr   = in_inst[11:7];
    dec.funct3    = funct3;
    dec.imm_type  = IMM_I;
    dec.alu_op    = ALU_ADD;
    dec_bad       = 1'b0;
    dec_range_bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_op = base_alu(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
            else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
            else                       dec_bad    = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M) dec.alu_op = ALU_MULDIV;
            else          dec_bad    = 1'b1;
          end
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.uses_rs1  = 1'b1;
        case (funct3)
          3'b001: begin
            dec.alu_op = ALU_SLL;
            dec_bad    = (funct7 != 7'b0000000);
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      dec.alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
            else                           dec_bad    = 1'b1;
          end
          default: dec.alu_op = base_alu(funct3);
        endcase
      end
      OPC_LOAD: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.uses_rs1  = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.imm_type  = IMM_S;
      end
      OPC_BRANCH: begin
        dec.branch   = 1'b1;
        dec.alu_op   = ALU_SUB;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.imm_type = IMM_B;
      end
      OPC_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm_type  = IMM_J;
      end
      OPC_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.uses_rs1  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.imm_type  = IMM_U;
      end
      default: dec_bad = 1'b1;
    endcase
    // Only register fields the instruction actually reads or writes are range checked.
    dec_range_bad = (dec.uses_rs1  && ({27'd0, dec.rs1_addr} >= NREG)) ||
                    (dec.uses_rs2  && ({27'd0, dec.rs2_addr} >= NREG)) ||
                    (dec.reg_write && ({27'd0, dec.rd_addr}  >= NREG));
    if (dec_bad || dec_range_bad) begin
      dec.illegal   = 1'b1;
      dec.alu_op    = ALU_ADD;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

  entry_t     head;
  entry_t     skid;
  logic       head_valid;
  logic       skid_valid;
  logic       ld_hz;
  logic [4:0] ld_rd;
  logic       hazard;
  logic       accept;
  logic       fire;

  assign hazard = ld_hz && head_valid &&
                  ((head.uses_rs1 && (head.rs1_addr == ld_rd)) ||
                   (head.uses_rs2 && (head.rs2_addr == ld_rd)));
  assign out_valid = head_valid && !hazard;
  assign fire      = out_valid && out_ready;
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;

  // Skid is only ever filled while head is occupied and not firing, so accept and
  // a full skid are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head       <= '0;
      skid       <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (fire) begin
      if (skid_valid) begin
        head       <= skid;
        skid_valid <= 1'b0;
      end else if (accept) begin
        head <= dec;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      if (head_valid) begin
        skid       <= dec;
        skid_valid <= 1'b1;
      end else begin
        head       <= dec;
        head_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_hz      <= 1'b0;
      ld_rd      <= 5'd0;
      bubble_cnt <= 16'd0;
    end else begin
      ld_hz <= !flush && fire && head.mem_read && (head.rd_addr != 5'd0);
      if (fire) ld_rd <= head.rd_addr;
      if (hazard && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign out_pc        = head.pc;
  assign out_rs1_addr  = head.rs1_addr;
  assign out_rs2_addr  = head.rs2_addr;
  assign out_rd_addr   = head.rd_addr;
  assign out_imm_type  = head.imm_type;
  assign out_funct3    = head.funct3;
  assign out_alu_op    = head.alu_op;
  assign out_reg_write = head.reg_write;
  assign out_mem_read  = head.mem_read;
  assign out_mem_write = head.mem_write;
  assign out_branch    = head.branch;
  assign out_jump      = head.jump;
  assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus random traffic, checked every
// cycle against a queue-based transaction model of the decode stage.
module tb_id_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [2:0]  out_imm_type, out_funct3;
  logic [3:0]  out_alu_op;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;
  logic [15:0] bubble_cnt;

  logic        in_valid_m, in_ready_m, flush_m, out_valid_m, out_ready_m;
  logic [31:0] in_inst_m, in_pc_m, out_pc_m;
  logic [4:0]  out_rs1_addr_m, out_rs2_addr_m, out_rd_addr_m;
  logic [2:0]  out_imm_type_m, out_funct3_m;
  logic [3:0]  out_alu_op_m;
  logic        out_reg_write_m, out_mem_read_m, out_mem_write_m, out_branch_m, out_jump_m, out_illegal_m;
  logic [15:0] bubble_cnt_m;

  id_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_imm_type(out_imm_type), .out_funct3(out_funct3), .out_alu_op(out_alu_op),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal), .bubble_cnt(bubble_cnt)
  );

  id_stage_pipe #(.XLEN(32), .NREG(16), .ENABLE_M(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m), .in_inst(in_inst_m),
    .in_pc(in_pc_m), .flush(flush_m), .out_valid(out_valid_m), .out_ready(out_ready_m), .out_pc(out_pc_m),
    .out_rs1_addr(out_rs1_addr_m), .out_rs2_addr(out_rs2_addr_m), .out_rd_addr(out_rd_addr_m),
    .out_imm_type(out_imm_type_m), .out_funct3(out_funct3_m), .out_alu_op(out_alu_op_m),
    .out_reg_write(out_reg_write_m), .out_mem_read(out_mem_read_m), .out_mem_write(out_mem_write_m),
    .out_branch(out_branch_m), .out_jump(out_jump_m), .out_illegal(out_illegal_m), .bubble_cnt(bubble_cnt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [62:0] obs_head, obs_head_m;
  assign obs_head = {out_pc, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm_type, out_funct3,
                     out_alu_op, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal};
  assign obs_head_m = {out_pc_m, out_rs1_addr_m, out_rs2_addr_m, out_rd_addr_m, out_imm_type_m, out_funct3_m,
                       out_alu_op_m, out_reg_write_m, out_mem_read_m, out_mem_write_m, out_branch_m,
                       out_jump_m, out_illegal_m};

  int          checks = 0;
  int          passes = 0;
  logic [63:0] mq[$];
  bit          m_hz;
  logic [4:0]  m_ld_rd;
  int          m_bub;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic [31:0] m_list [10];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Expected decode as {pc, rs1, rs2, rd, imm_type, funct3, alu_op, wr, mrd, mwr, br, jmp, illegal}.
  function automatic logic [62:0] ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                             input bit en_m, input int nreg);
    logic [3:0] plain_alu [8];
    logic [6:0] opc, f7;
    logic [2:0] f3, imm;
    logic [3:0] alu;
    int         rd, rs1, rs2;
    bit         wr, lr, sw, br, jp, bad, u1, u2;
    plain_alu = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20];
    {wr, lr, sw, br, jp, bad, u1, u2} = '0;
    alu = 4'd0; imm = 3'd0;
    case (opc)
      7'h33: begin
        wr = 1; u1 = 1; u2 = 1;
        if (f7 == 7'h00) alu = plain_alu[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 4'd7;
        else if (f7 == 7'h01 && en_m) alu = 4'd10;
        else bad = 1;
      end
      7'h13: begin
        wr = 1; u1 = 1;
        if (f3 == 3'd1) begin alu = 4'd5; bad = (f7 != 7'h00); end
        else if (f3 == 3'd5) begin
          if (f7 == 7'h00) alu = 4'd6;
          else if (f7 == 7'h20) alu = 4'd7;
          else bad = 1;
        end else alu = plain_alu[f3];
      end
      7'h03: begin wr = 1; lr = 1; u1 = 1; end
      7'h23: begin sw = 1; u1 = 1; u2 = 1; imm = 3'd1; end
      7'h63: begin br = 1; alu = 4'd1; u1 = 1; u2 = 1; imm = 3'd2; end
      7'h6f: begin jp = 1; wr = 1; imm = 3'd4; end
      7'h67: begin jp = 1; wr = 1; u1 = 1; end
      7'h37, 7'h17: begin wr = 1; imm = 3'd3; end
      default: bad = 1;
    endcase
    if ((u1 && rs1 >= nreg) || (u2 && rs2 >= nreg) || (wr && rd >= nreg)) bad = 1;
    if (bad) begin {wr, lr, sw, br, jp} = '0; alu = 4'd0; end
    return {pc, inst[19:15], inst[24:20], inst[11:7], imm, f3, alu, wr, lr, sw, br, jp, bad};
  endfunction

  function automatic bit ref_depends(input logic [31:0] inst, input logic [4:0] r);
    logic [6:0] o;
    bit u1, u2;
    o  = inst[6:0];
    u1 = o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    u2 = o inside {7'h33, 7'h23, 7'h63};
    return (u1 && inst[19:15] == r) || (u2 && inst[24:20] == r);
  endfunction

  function automatic logic [31:0] randInst();
    logic [4:0] a, b, d;
    logic [2:0] f3;
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); d = 5'($urandom_range(0, 3));
    f3 = 3'($urandom);
    case ($urandom_range(0, 9))
      0: return {7'h00, b, a, f3, d, 7'h33};
      1: return {7'h20, b, a, f3, d, 7'h33};
      2: return {7'h01, b, a, f3, d, 7'h33};
      3: return {($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h20, b, a, f3, d, 7'h13};
      4: return {12'($urandom), a, 3'b010, d, 7'h03};
      5: return {7'($urandom), b, a, 3'b010, 5'($urandom), 7'h23};
      6: return {7'($urandom), b, a, f3, 5'($urandom), 7'h63};
      7: return {20'($urandom), d, ($urandom_range(0, 1) == 0) ? 7'h6f : 7'h37};
      8: return $urandom;
      default: return {12'($urandom), a, 3'b000, d, 7'h67};
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic applyStimulus(input bit iv, input logic [31:0] inst, input bit ordy, input bit fl);
    logic [63:0] head_e;
    logic [62:0] d;
    bit          hz, exp_valid, fire, accept, nxt_hz;
    in_valid = iv; in_inst = inst; in_pc = pc_ctr; out_ready = ordy; flush = fl;
    #2;
    head_e    = (mq.size() > 0) ? mq[0] : 64'd0;
    hz        = m_hz && (mq.size() > 0) && ref_depends(head_e[31:0], m_ld_rd);
    exp_valid = (mq.size() > 0) && !hz;
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
    checkOutput("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    checkOutput("bubble_cnt", {48'd0, bubble_cnt}, 64'(m_bub));
    if (exp_valid) checkOutput("head", {1'b0, obs_head}, {1'b0, ref_decode(head_e[31:0], head_e[63:32], 0, 32)});
    if (hz && m_bub < 65535) m_bub++;
    if (fl) begin
      mq.delete();
      m_hz = 0;
    end else begin
      fire   = exp_valid && ordy;
      accept = iv && (mq.size() < 2);
      nxt_hz = 0;
      if (fire) begin
        d       = ref_decode(head_e[31:0], head_e[63:32], 0, 32);
        nxt_hz  = d[4] && (head_e[11:7] != 5'd0);
        m_ld_rd = head_e[11:7];
        void'(mq.pop_front());
      end
      if (accept) mq.push_back({pc_ctr, inst});
      m_hz = nxt_hz;
    end
    pc_ctr += 4;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_bubble_cnt", {48'd0, bubble_cnt}, 64'd0);
    mq.delete(); m_hz = 0; m_bub = 0;
    in_valid = 0; flush = 0; out_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 0;
    in_valid_m = 0; in_inst_m = 0; in_pc_m = 0; flush_m = 0; out_ready_m = 1;
    m_hz = 0; m_ld_rd = 0; m_bub = 0;
    m_list = '{32'h022081B3, 32'h00100A13, {7'h01, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33},
               {7'h20, 5'd2, 5'd1, 3'd5, 5'd3, 7'h33}, {7'h20, 5'd3, 5'd1, 3'd5, 5'd4, 7'h13},
               32'h00012283, {7'h00, 5'd2, 5'd16, 3'd0, 5'd1, 7'h33},
               {12'h004, 5'd1, 3'b010, 5'd17, 7'h03}, 32'h000002B7,
               {7'h00, 5'd15, 5'd14, 3'd0, 5'd13, 7'h33}};
    @(posedge clk);
    #1;
    applyReset();

    $display("[TB] streaming addi");
    for (int i = 0; i < 8; i++) applyStimulus(1, 32'h00100093, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, 1, 0);

    $display("[TB] backpressure");
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h00100093 + (i << 7), 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 0);

    $display("[TB] load-use");
    applyReset();
    applyStimulus(1, 32'h00012283, 1, 0);
    applyStimulus(1, 32'h00128333, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 0);
    checkOutput("t3_one_bubble", {48'd0, bubble_cnt}, 64'd1);
    applyStimulus(1, 32'h00012283, 1, 0);
    applyStimulus(1, 32'h00138333, 1, 0);
    applyStimulus(1, 32'h00012003, 1, 0);
    applyStimulus(1, 32'h00100333, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 0);
    checkOutput("t3_no_more_bubbles", {48'd0, bubble_cnt}, 64'd1);

    $display("[TB] M extension and register range");
    applyStimulus(1, 32'h022081B3, 1, 0);
    applyStimulus(0, 32'h0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid_m = 1; in_inst_m = m_list[i]; in_pc_m = 32'h2000 + 32'(i * 4);
      applyStimulus(0, 32'h0, 1, 0);
      in_valid_m = 0;
      checkOutput("m_valid", {63'd0, out_valid_m}, 64'd1);
      checkOutput("m_head", {1'b0, obs_head_m}, {1'b0, ref_decode(m_list[i], 32'h2000 + 32'(i * 4), 1, 16)});
      applyStimulus(0, 32'h0, 1, 0);
    end

    $display("[TB] flush");
    applyReset();
    applyStimulus(1, 32'h00100093, 0, 0);
    applyStimulus(1, 32'h00200113, 0, 0);
    applyStimulus(1, 32'h00300193, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 0);

    $display("[TB] reset with skid full");
    applyStimulus(1, 32'h00100093, 0, 0);
    applyStimulus(1, 32'h00200113, 0, 0);
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h00100093, 1, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) applyReset();
      applyStimulus($urandom_range(0, 3) != 0, randInst(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
